// File: rtl/cipher_frame_buffer.sv
// cipher_frame_buffer: captures one ciphertext frame and replays it under valid/ready.
// Ports: clk, rst (async active-low), flush, wr_valid/wr_data/wr_last (capture side),
//        rd_start, rd_ready/rd_valid/rd_data/rd_last (replay side), frame_len, busy, overflow.
// Option: define CFB_REPLAY_HOLD_EN to keep the frame after replay so it can be replayed again.
module cipher_frame_buffer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              rd_start,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W:0]   frame_len,
  output logic              busy,
  output logic              overflow
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  typedef enum logic [1:0] {IDLE, FILL, HOLD, REPLAY} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wptr, rptr, rptr_nxt;
  logic full, new_frame, wr_en, xfer, done;
  always_comb begin
    full = frame_len == DEPTH;
    new_frame = wr_valid && (state == IDLE || state == HOLD);
    wr_en = !flush && (new_frame || (state == FILL && wr_valid && !full));
    xfer = state == REPLAY && rd_valid && rd_ready;
    done = xfer && rd_last;
    rptr_nxt = rptr + 1'b1;
    state_nxt = state;
    case (state)
      IDLE, HOLD: state_nxt = new_frame ? (wr_last ? HOLD : FILL)
                            : (state == HOLD && rd_start) ? REPLAY : state;
      FILL:       state_nxt = (!wr_valid || wr_last) ? HOLD : FILL;
`ifdef CFB_REPLAY_HOLD_EN
      REPLAY:     state_nxt = done ? HOLD : REPLAY;
`else
      REPLAY:     state_nxt = done ? IDLE : REPLAY;
`endif
      default:    state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end
  // storage is deliberately left out of reset
  always_ff @(posedge clk)
    if (wr_en) mem[new_frame ? '0 : wptr] <= wr_data;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      frame_len <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_last <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
        frame_len <= '0;
        rd_valid <= 1'b0;
        rd_last <= 1'b0;
        overflow <= 1'b0;
      end else if (new_frame) begin
        wptr <= ADDR_W'(1);
        frame_len <= ONE;
        overflow <= 1'b0;
      end else if (state == FILL && wr_valid) begin
        if (full) overflow <= 1'b1;
        else begin
          wptr <= wptr + 1'b1;
          frame_len <= frame_len + 1'b1;
        end
      end else if (state == HOLD && rd_start) begin
        rptr <= '0;
        rd_valid <= 1'b1;
        rd_data <= mem[0];
        rd_last <= frame_len == ONE;
      end else if (xfer) begin
        if (rd_last) begin
          rd_valid <= 1'b0;
          rd_last <= 1'b0;
`ifndef CFB_REPLAY_HOLD_EN
          frame_len <= '0;
`endif
        end else begin
          rptr <= rptr_nxt;
          rd_data <= mem[rptr_nxt];
          rd_last <= {1'b0, rptr_nxt} == frame_len - ONE;
        end
      end
      // writes arriving mid-replay are dropped but flagged
      if (!flush && state == REPLAY && wr_valid) overflow <= 1'b1;
    end
  end
  assign busy = state == FILL || state == REPLAY;
endmodule

// File: tb/tb_cipher_frame_buffer.sv
// tb_cipher_frame_buffer: randomized and directed checks of cipher_frame_buffer against a queue model.
module tb_cipher_frame_buffer;
  logic clk = 0, rst = 0, flush = 0, wr_valid = 0, wr_last = 0, rd_start = 0, rd_ready = 0;
  logic [7:0] wr_data = 0, rd_data;
  logic rd_valid, rd_last, busy, overflow;
  logic [2:0] frame_len;
  int n_checks = 0, n_errors = 0;
  logic [7:0] q[$];
  bit ovf = 0, filling = 0;

  cipher_frame_buffer #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_last(wr_last), .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_last(rd_last), .frame_len(frame_len), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task step;
    @(posedge clk);
    #1;
  endtask

  task wr(input logic [7:0] d, input bit last);
    if (!filling) begin
      q.delete();
      ovf = 0;
      filling = 1;
    end
    if (q.size() < 4) q.push_back(d);
    else ovf = 1;
    if (last) filling = 0;
    wr_valid = 1;
    wr_data = d;
    wr_last = last;
    step;
    wr_valid = 0;
    wr_last = 0;
  endtask

  task wr_end;
    step;
    filling = 0;
    check("fill_len", frame_len, q.size());
    check("fill_ovf", overflow, ovf);
    check("fill_busy", busy, 0);
  endtask

  task clear_model;
    q.delete();
    ovf = 0;
    filling = 0;
  endtask

  // mode 0: always ready, 1: stalled 4 cycles first, 2: random ready
  task replay(input int mode, input bit inj);
    int idx, cyc, len;
    bit r;
    len = q.size();
    rd_start = 1;
    step;
    rd_start = 0;
    if (len == 0) begin
      check("ign_valid", rd_valid, 0);
      check("ign_len", frame_len, 0);
      return;
    end
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < 200) begin
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, q[idx]);
      check("rd_last", rd_last, idx == len - 1);
      r = mode == 0 ? 1 : mode == 1 ? (cyc >= 4) : 1'($urandom_range(0, 1));
      rd_ready = r;
      wr_valid = inj && cyc == 0;
      wr_data = 8'hEE;
      step;
      rd_ready = 0;
      wr_valid = 0;
      if (r) idx++;
      cyc++;
    end
    if (inj) ovf = 1;
    check("replay_done", idx, len);
    check("end_valid", rd_valid, 0);
    check("end_busy", busy, 0);
`ifndef CFB_REPLAY_HOLD_EN
    q.delete();
`endif
    check("end_len", frame_len, q.size());
    check("end_ovf", overflow, ovf);
  endtask

  initial begin
    int n;
    bit l;
    repeat (2) step;
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_last", rd_last, 0);
    check("rst_len", frame_len, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    rst = 1;
    step;
    // basic loopback
    wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 1);
    wr_end;
    replay(0, 0);
    // backpressure
    wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 1);
    wr_end;
    replay(1, 0);
    // overflow on a 4-deep store
    for (int i = 0; i < 6; i++) wr(8'hA0 + 8'(i), 0);
    wr_end;
    replay(0, 0);
    wr(8'h55, 0);
    check("newframe_len", frame_len, 1);
    check("newframe_ovf", overflow, 0);
    wr_end;
    // frame closed by valid drop, then rewrite wins over rd_start
    wr(8'h01, 0); wr(8'h02, 0);
    wr_end;
    rd_start = 1;
    wr(8'h77, 0);
    rd_start = 0;
    check("rewrite_busy", busy, 1);
    check("rewrite_len", frame_len, 1);
    check("rewrite_valid", rd_valid, 0);
    wr_end;
    // flush mid-replay
    for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i), i == 3);
    wr_end;
    rd_start = 1; step; rd_start = 0;
    rd_ready = 1; step;
    check("pre_flush_data", rd_data, 8'hC1);
    flush = 1; step; flush = 0; rd_ready = 0;
    clear_model;
    check("flush_valid", rd_valid, 0);
    check("flush_len", frame_len, 0);
    check("flush_busy", busy, 0);
    // async reset mid-replay
    for (int i = 0; i < 4; i++) wr(8'hD0 + 8'(i), i == 3);
    wr_end;
    rd_start = 1; step; rd_start = 0;
    rd_ready = 1; step;
    check("pre_rst_valid", rd_valid, 1);
    #3 rst = 0;
    #1;
    check("arst_valid", rd_valid, 0);
    check("arst_last", rd_last, 0);
    check("arst_len", frame_len, 0);
    check("arst_busy", busy, 0);
    #1 rst = 1;
    step;
    rd_ready = 0;
    clear_model;
    check("post_rst_valid", rd_valid, 0);
    // repeat replay: works only with the hold option
    wr(8'h01, 0); wr(8'h02, 1);
    wr_end;
    replay(0, 0);
    replay(0, 0);
    // randomized frames
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(1, 6);
      l = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) wr(8'($urandom_range(0, 255)), l && i == n - 1);
      wr_end;
      replay(2, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) replay(2, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
